// File: rtl/uart_pkg.sv
// Shared UART constants, word/byte types and the byte-lane placement helper.
package uart_pkg;

    localparam int unsigned UART_BYTE_W         = 8;
    localparam int unsigned UART_WORD_W         = 32;
    localparam int unsigned UART_BYTES_PER_WORD = 4;

    typedef logic [UART_WORD_W-1:0]                 uart_word_t;
    typedef logic [UART_BYTE_W-1:0]                 uart_byte_t;
    typedef logic [$clog2(UART_BYTES_PER_WORD)-1:0] uart_idx_t;

    // Returns w with byte b written into the lane selected by idx and the
    // endianness: little => lane idx, big => lane (BYTES_PER_WORD-1-idx).
    function automatic uart_word_t place_byte(
        input uart_word_t w,
        input uart_idx_t  idx,
        input uart_byte_t b,
        input logic       little
    );
        uart_word_t  r;
        int unsigned lane;
        r    = w;
        lane = little ? 32'(idx) : (UART_BYTES_PER_WORD - 1 - 32'(idx));
        r[lane*UART_BYTE_W +: UART_BYTE_W] = b;
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_word_packer_if.sv
// Word-stream valid/ready bus from the packer to the program loader.
interface uart_rx_word_packer_if;

    uart_pkg::uart_word_t word_data;
    logic                 word_valid;
    logic                 word_ready;

    modport master (output word_data, output word_valid, input word_ready);
    modport slave  (input word_data, input word_valid, output word_ready);

endinterface

// File: rtl/uart_rx_word_packer_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count and flush.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty = (r_count == '0);
    assign full  = (r_count == FULL_CNT);
    assign level = r_count;

    // A push into a full FIFO is only taken when a pop frees the head slot.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    // Head is zero while empty so the output bus is clean after reset/flush.
    assign head = empty ? '0 : r_mem[r_rd_ptr];

    // Storage write; contents need no reset since head is masked while empty.
    always_ff @(posedge clk) begin
        if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy update; flush overrides push and pop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_word_packer.sv
// Packs UART receiver bytes into 32-bit words and buffers them in a FWFT FIFO,
// with sticky framing-error and overflow flags cleared by a synchronous clear.
module uart_rx_word_packer
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH         = 4,
    parameter logic        LITTLE_ENDIAN = 1'b1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [UART_BYTE_W-1:0]    rdata,
    input  logic                      rdata_ready,
    input  logic                      ferr,
    input  logic                      clear,
    uart_rx_word_packer_if.master     word_if,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      ferr_seen,
    output logic                      overflow
);

    uart_idx_t  r_idx;
    uart_word_t r_asm;
    logic       r_ferr_seen;
    logic       r_overflow;

    logic       w_byte_ok;
    logic       w_byte_err;
    logic       w_last;
    uart_word_t w_word;
    logic       w_push_req;
    logic       w_pop;
    logic       w_push;
    logic       w_drop;
    logic       w_empty;
    logic       w_full;
    uart_word_t w_head;

    // clear masks every strobe and pop in its cycle.
    assign w_byte_ok  = rdata_ready & ~ferr & ~clear;
    assign w_byte_err = rdata_ready &  ferr & ~clear;
    assign w_last     = (r_idx == uart_idx_t'(UART_BYTES_PER_WORD - 1));

    // The 4th byte bypasses the assembly register so the full word is pushed
    // on the same edge that strobes its last byte.
    assign w_word     = place_byte(r_asm, r_idx, rdata, LITTLE_ENDIAN);
    assign w_push_req = w_byte_ok & w_last;
    assign w_pop      = ~w_empty & word_if.word_ready & ~clear;
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;

    // Byte index and partial-word assembly.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_idx <= '0;
            r_asm <= '0;
        end else if (clear || w_byte_err) begin
            r_idx <= '0;
        end else if (w_byte_ok) begin
            r_idx <= w_last ? '0 : r_idx + 1'b1;
            r_asm <= w_word;
        end
    end

    // Sticky framing-error and overflow flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ferr_seen <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (clear) begin
            r_ferr_seen <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_byte_err) r_ferr_seen <= 1'b1;
            if (w_drop)     r_overflow  <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (UART_WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (clear),
        .push      (w_push),
        .push_data (w_word),
        .pop       (w_pop),
        .head      (w_head),
        .empty     (w_empty),
        .full      (w_full),
        .level     (level)
    );

    assign word_if.word_data  = w_head;
    assign word_if.word_valid = ~w_empty;
    assign ferr_seen          = r_ferr_seen;
    assign overflow           = r_overflow;

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Bench for uart_rx_word_packer: little- and big-endian instances share the
// stimulus and are checked against a queue-based reference model, a directed
// vector table and hand-written multi-cycle sequences.
module tb_uart_rx_word_packer;
    import uart_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rstn;
    logic          clear;
    logic          rdata_ready;
    logic          ferr;
    logic          word_ready;
    logic [7:0]    rdata;
    logic [LW-1:0] le_level, be_level;
    logic          le_ferr, le_ovf, be_ferr, be_ovf;

    uart_rx_word_packer_if le_if ();
    uart_rx_word_packer_if be_if ();
    assign le_if.word_ready = word_ready;
    assign be_if.word_ready = word_ready;

    always #5 clk = ~clk;

    uart_rx_word_packer #(.DEPTH(DEPTH), .LITTLE_ENDIAN(1'b1)) u_le (
        .clk(clk), .rstn(rstn), .rdata(rdata), .rdata_ready(rdata_ready),
        .ferr(ferr), .clear(clear), .word_if(le_if), .level(le_level),
        .ferr_seen(le_ferr), .overflow(le_ovf));

    uart_rx_word_packer #(.DEPTH(DEPTH), .LITTLE_ENDIAN(1'b0)) u_be (
        .clk(clk), .rstn(rstn), .rdata(rdata), .rdata_ready(rdata_ready),
        .ferr(ferr), .clear(clear), .word_if(be_if), .level(be_level),
        .ferr_seen(be_ferr), .overflow(be_ovf));

    // ---------------- reference model ----------------
    logic [7:0]  m_part[$];
    uart_word_t  m_le[$];
    uart_word_t  m_be[$];
    logic        m_ferr, m_ovf;

    int n_vec = 0;
    int n_err = 0;

    function automatic uart_word_t pack(input logic [7:0] b[$], input bit little);
        uart_word_t w;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            if (little) w = w | (uart_word_t'(b[i]) << (8 * i));
            else        w = w | (uart_word_t'(b[i]) << (8 * (3 - i)));
        end
        return w;
    endfunction

    task automatic model_reset();
        m_part.delete(); m_le.delete(); m_be.delete();
        m_ferr = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic model_step(input logic rdy, input logic [7:0] d,
                              input logic fe, input logic clr, input logic wr);
        bit         pop;
        bit         have;
        uart_word_t wl, wb;
        have = 0; wl = '0; wb = '0;
        if (clr) begin
            model_reset();
        end else begin
            pop = (m_le.size() > 0) && wr;
            if (rdy) begin
                if (fe) begin
                    m_part.delete();
                    m_ferr = 1'b1;
                end else begin
                    m_part.push_back(d);
                    if (m_part.size() == 4) begin
                        have = 1;
                        wl = pack(m_part, 1);
                        wb = pack(m_part, 0);
                        m_part.delete();
                    end
                end
            end
            if (pop) begin
                void'(m_le.pop_front());
                void'(m_be.pop_front());
            end
            if (have) begin
                if (m_le.size() < DEPTH) begin
                    m_le.push_back(wl);
                    m_be.push_back(wb);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("le_valid", 32'(le_if.word_valid), 32'(m_le.size() > 0));
        chk("be_valid", 32'(be_if.word_valid), 32'(m_be.size() > 0));
        chk("le_data",  le_if.word_data, (m_le.size() > 0) ? m_le[0] : 32'h0);
        chk("be_data",  be_if.word_data, (m_be.size() > 0) ? m_be[0] : 32'h0);
        chk("le_level", 32'(le_level), 32'(m_le.size()));
        chk("be_level", 32'(be_level), 32'(m_be.size()));
        chk("le_ferr",  32'(le_ferr), 32'(m_ferr));
        chk("be_ferr",  32'(be_ferr), 32'(m_ferr));
        chk("le_ovf",   32'(le_ovf),  32'(m_ovf));
        chk("be_ovf",   32'(be_ovf),  32'(m_ovf));
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge.
    task automatic step(input logic rdy, input logic [7:0] d, input logic fe,
                        input logic clr, input logic wr);
        rdata_ready = rdy; rdata = d; ferr = fe; clear = clr; word_ready = wr;
        @(posedge clk);
        model_step(rdy, d, fe, clr, wr);
        @(negedge clk);
        chk_model();
        rdata_ready = 1'b0; ferr = 1'b0; clear = 1'b0; word_ready = 1'b0;
    endtask

    // Sends w as four bytes, low byte first; word_ready only with the 4th.
    task automatic send4(input logic [31:0] w, input logic wr_last);
        step(1'b1, w[7:0],   1'b0, 1'b0, 1'b0);
        step(1'b1, w[15:8],  1'b0, 1'b0, 1'b0);
        step(1'b1, w[23:16], 1'b0, 1'b0, 1'b0);
        step(1'b1, w[31:24], 1'b0, 1'b0, wr_last);
    endtask

    typedef struct {
        logic          rdy;
        logic [7:0]    d;
        logic          fe;
        logic          clr;
        logic          wr;
        logic          ev;
        uart_word_t    ele;
        uart_word_t    ebe;
        logic [LW-1:0] elev;
        logic          eferr;
        logic          eovf;
    } vec_t;

    vec_t tbl[19];

    initial begin
        // rdy, d, fe, clr, wr | valid, le_data, be_data, level, ferr_seen, overflow
        tbl[0]  = '{1, 8'h78, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0};
        tbl[1]  = '{1, 8'h56, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0};
        tbl[2]  = '{1, 8'h34, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0};
        tbl[3]  = '{1, 8'h12, 0, 0, 0, 1, 32'h12345678, 32'h78563412, 1, 0, 0};
        tbl[4]  = '{0, 8'h00, 0, 1, 0, 0, 32'h0, 32'h0, 0, 0, 0};
        tbl[5]  = '{1, 8'hDE, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0};
        tbl[6]  = '{1, 8'hAD, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0};
        tbl[7]  = '{1, 8'hBE, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0};
        tbl[8]  = '{1, 8'hEF, 0, 0, 0, 1, 32'hEFBEADDE, 32'hDEADBEEF, 1, 0, 0};
        tbl[9]  = '{0, 8'h00, 0, 1, 0, 0, 32'h0, 32'h0, 0, 0, 0};
        tbl[10] = '{1, 8'h11, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0};
        tbl[11] = '{1, 8'h22, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0};
        tbl[12] = '{1, 8'h33, 1, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0};
        tbl[13] = '{1, 8'hAA, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0};
        tbl[14] = '{1, 8'hBB, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0};
        tbl[15] = '{1, 8'hCC, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0};
        tbl[16] = '{1, 8'hDD, 0, 0, 0, 1, 32'hDDCCBBAA, 32'hAABBCCDD, 1, 1, 0};
        tbl[17] = '{0, 8'h00, 0, 0, 1, 0, 32'h0, 32'h0, 0, 1, 0};
        tbl[18] = '{0, 8'h00, 0, 1, 0, 0, 32'h0, 32'h0, 0, 0, 0};

        rstn = 1'b0; clear = 1'b0; rdata_ready = 1'b0; ferr = 1'b0;
        word_ready = 1'b0; rdata = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_model();
        rstn = 1'b1;

        // Directed table
        for (int i = 0; i < 19; i++) begin
            step(tbl[i].rdy, tbl[i].d, tbl[i].fe, tbl[i].clr, tbl[i].wr);
            chk($sformatf("tbl%0d_valid", i), 32'(le_if.word_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_le", i), le_if.word_data, tbl[i].ele);
            chk($sformatf("tbl%0d_be", i), be_if.word_data, tbl[i].ebe);
            chk($sformatf("tbl%0d_level", i), 32'(le_level), 32'(tbl[i].elev));
            chk($sformatf("tbl%0d_ferr", i), 32'(le_ferr), 32'(tbl[i].eferr));
            chk($sformatf("tbl%0d_ovf", i), 32'(le_ovf), 32'(tbl[i].eovf));
        end

        // Overflow: 20 bytes with no pops keeps the first 4 words only
        for (int k = 0; k < 5; k++) send4(32'hA0A0A000 + 32'(k), 1'b0);
        chk("ovf_level", 32'(le_level), 32'd4);
        chk("ovf_flag", 32'(le_ovf), 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ovf_order%0d", k), le_if.word_data, 32'hA0A0A000 + 32'(k));
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        end
        chk("ovf_drained", 32'(le_if.word_valid), 32'd0);
        chk("ovf_sticky", 32'(le_ovf), 32'd1);

        // Full boundary: 4th byte coincides with a pop while full
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) send4(32'hB0B0B000 + 32'(k), 1'b0);
        send4(32'hB0B0B0FF, 1'b1);
        chk("full_level", 32'(le_level), 32'd4);
        chk("full_ovf", 32'(le_ovf), 32'd0);
        chk("full_head", le_if.word_data, 32'hB0B0B001);
        for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("full_tail", le_if.word_data, 32'hB0B0B0FF);

        // clear together with a 4th-byte strobe, 2 words buffered
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        send4(32'hC0C0C000, 1'b0);
        send4(32'hC0C0C001, 1'b0);
        step(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h04, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h05, 1'b0, 1'b1, 1'b1);
        chk("clr_level", 32'(le_level), 32'd0);
        chk("clr_valid", 32'(le_if.word_valid), 32'd0);
        chk("clr_ferr", 32'(le_ferr), 32'd0);
        chk("clr_ovf", 32'(le_ovf), 32'd0);
        send4(32'h0BADF00D, 1'b0);
        chk("clr_fresh", le_if.word_data, 32'h0BADF00D);
        chk("clr_fresh_level", 32'(le_level), 32'd1);

        // Asynchronous reset mid-word
        step(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h21, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h43, 1'b0, 1'b0, 1'b0);
        #2 rstn = 1'b0;
        #1;
        chk("rst_valid", 32'(le_if.word_valid), 32'd0);
        chk("rst_data", le_if.word_data, 32'd0);
        chk("rst_level", 32'(le_level), 32'd0);
        chk("rst_ferr", 32'(le_ferr), 32'd0);
        chk("rst_ovf", 32'(le_ovf), 32'd0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        send4(32'h87654321, 1'b0);
        chk("rst_fresh", le_if.word_data, 32'h87654321);

        // Randomized: slow drain phase then fast drain phase
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            logic wr;
            wr = (n < 1500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 63) == 0), wr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_word_packer.md
# uart_rx_word_packer

Packs the byte stream from the UART receiver into 32-bit words and buffers them in a small first-word-fall-through FIFO for the CPU program loader. Sits directly downstream of the receiver. Consumes its `rdata`/`rdata_ready`/`ferr` outputs and presents words on a valid/ready interface. Framing errors and FIFO overflow are reported as sticky flags, which are cleared by `clear`.

## Interface
- `DEPTH`, 4: FIFO depth in words. Power of two, ≥2.
- `LITTLE_ENDIAN`, 1: 1 = first received byte goes to bits [7:0]; 0 = first byte goes to bits [31:24].
- `clk` input 1: single clock, rising edge.
- `rstn` input 1: reset, asynchronous, active-low.
- `rdata` input 8: received byte; sampled only when `rdata_ready`=1.
- `rdata_ready` input 1: one-cycle byte strobe from the receiver; back-to-back strobes are legal.
- `ferr` input 1: framing error; qualified by `rdata_ready`.
- `clear` input 1: synchronous flush of the partial word, the FIFO and both sticky flags.
- `word_data` output 32: FIFO head word; valid only while `word_valid`=1.
- `word_valid` output 1: FIFO not empty.
- `word_ready` input 1: consumer accepts the head word when `word_valid`=1.
- `level` output $clog2(DEPTH)+1: number of words in the FIFO.
- `ferr_seen` output 1: sticky; a framing-error byte was received.
- `overflow` output 1: sticky; a completed word was dropped because the FIFO was full.

## Operation
- **Reset** (`rstn`=0, asynchronous):
  - byte index = 0; assembly register = 0; FIFO pointers = 0.
  - `word_valid`=0, `level`=0, `word_data`=0.
  - `ferr_seen`=0, `overflow`=0.
- **Byte accept** (`rdata_ready`=1 and `ferr`=0):
  - Byte index 0..2: write the byte into its lane of the assembly register, then increment the index.
  - Byte index 3: form the full word from the 3 held bytes plus `rdata`, in the same cycle. Push it into the FIFO; the index wraps to 0.
- **Lane mapping:** index i → bits [8i+7:8i] when `LITTLE_ENDIAN`=1; bits [31-8i:24-8i] when `LITTLE_ENDIAN`=0.
- **Error byte** (`rdata_ready`=1 and `ferr`=1):
  - The byte is discarded; the index resets to 0, so the partial word is abandoned.
  - `ferr_seen` is set.
  - No FIFO push.
- **Push while full:**
  - No pop in the same cycle: the word is dropped, `overflow` is set, the index still wraps to 0.
  - Pop in the same cycle: push and pop both occur and `level` is unchanged.
- **Pop** (`word_valid` and `word_ready`): the head advances. `word_ready` while empty has no effect.
- **Push and pop same cycle, not full:** both occur, `level` unchanged. When the FIFO is empty, a same-cycle pop is impossible (`word_valid`=0).
- **`clear`:**
  - Highest priority; any same-cycle strobe, push or pop is ignored.
  - Index → 0, FIFO emptied, `ferr_seen`=0, `overflow`=0.
- **Width rules:**
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - `level` counts 0..DEPTH and never wraps.

## Timing
- All state updates on the rising `clk` edge, except reset.
- 4th-byte strobe at edge N → `word_valid`=1 and `word_data` valid after edge N (cycle N+1).
- FWFT: `word_data` is driven combinationally from the head entry. No read latency.
- Pop at edge N → next head word (or `word_valid`=0) in cycle N+1.
- `level`, `ferr_seen` and `overflow` update on the same edge as the triggering event.
- No combinational path from `word_ready` to any output except through registered state.

## Structure
- **Shared package `uart_pkg`:**
  - `UART_BYTE_W`=8, `UART_WORD_W`=32, `UART_BYTES_PER_WORD`=4.
  - typedef `uart_word_t` (logic [31:0]).
- **Sub-module `sync_fifo`:**
  - Parameters WIDTH and DEPTH.
  - Ports: `push`, `push_data`, `pop`, `head`, `empty`, `full`, `level`.
  - Same clock and reset as the top.
- The top holds the byte index, assembly register, sticky flags and `clear` priority logic.

## Test plan
- **Little-endian packing:** bytes 0x78,0x56,0x34,0x12 (`ferr`=0), `word_ready`=0 → `word_data`=0x12345678, `word_valid`=1 the cycle after the 4th strobe, `level`=1.
- **Big-endian packing:** `LITTLE_ENDIAN`=0, bytes 0xDE,0xAD,0xBE,0xEF → `word_data`=0xDEADBEEF.
- **Framing error mid-word:** bytes 0x11,0x22, then 0x33 with `ferr`=1, then 0xAA,0xBB,0xCC,0xDD → `ferr_seen`=1, exactly one word 0xDDCCBBAA, `level`=1.
- **Overflow:** `DEPTH`=4, 20 bytes, `word_ready`=0 → `level`=4, `overflow`=1. The first 4 words are retained in order and the 5th is dropped.
- **Full boundary:** with the FIFO full, the 4th byte strobe coincides with `word_ready`=1 → the head pops, the new word enters at the tail, `level` stays 4, `overflow` stays 0.
- **Clear and reset:**
  - `clear` asserted in the same cycle as a 4th-byte strobe, with 2 words buffered → `level`=0, no push, flags 0. The next 4 bytes form a fresh word.
  - `rstn` pulsed low mid-word → all outputs 0 immediately, without waiting for a clock edge.
